// File: rtl/cmp_pkg.sv
// Shared definitions for the pipelined comparator: op encoding, relation
// flag bundle and the op-to-result mapping.
package cmp_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_GT = 3'd0;
  localparam logic [OP_W-1:0] OP_GE = 3'd1;
  localparam logic [OP_W-1:0] OP_LT = 3'd2;
  localparam logic [OP_W-1:0] OP_LE = 3'd3;
  localparam logic [OP_W-1:0] OP_EQ = 3'd4;
  localparam logic [OP_W-1:0] OP_NE = 3'd5;

  typedef struct packed {
    logic gt;
    logic eq;
    logic lt;
  } rel_t;

  function automatic logic op_is_reserved(input logic [OP_W-1:0] opc);
    logic rsv;
    case (opc)
      OP_GT, OP_GE, OP_LT, OP_LE, OP_EQ, OP_NE: rsv = 1'b0;
      default:                                 rsv = 1'b1;
    endcase
    return rsv;
  endfunction

  // Reserved codes resolve to 0 so a bad op can never assert a decision.
  function automatic logic op_result(input logic [OP_W-1:0] opc, input rel_t rel);
    logic res;
    case (opc)
      OP_GT:   res = rel.gt;
      OP_GE:   res = rel.gt | rel.eq;
      OP_LT:   res = rel.lt;
      OP_LE:   res = rel.lt | rel.eq;
      OP_EQ:   res = rel.eq;
      OP_NE:   res = ~rel.eq;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/cmp_core.sv
// Combinational magnitude comparator producing one-hot gt/eq/lt flags for
// unsigned or two's-complement operands.
module cmp_core
  import cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  logic [WIDTH-1:0] a_key_s;
  logic [WIDTH-1:0] b_key_s;
  logic             eq_s;
  logic             lt_s;

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  always_comb begin
    a_key_s = a;
    b_key_s = b;
    if (signed_mode) begin
      a_key_s[WIDTH-1] = ~a[WIDTH-1];
      b_key_s[WIDTH-1] = ~b[WIDTH-1];
    end else begin
      a_key_s[WIDTH-1] = a[WIDTH-1];
      b_key_s[WIDTH-1] = b[WIDTH-1];
    end
  end

  // Relation flags derived from a single equality and a single less-than.
  always_comb begin
    eq_s = (a_key_s == b_key_s);
    lt_s = (a_key_s < b_key_s);
    eq   = eq_s;
    lt   = lt_s & ~eq_s;
    gt   = ~lt_s & ~eq_s;
  end

endmodule

// File: rtl/comparator_pipe.sv
// Registered comparator with valid/ready handshakes, op decode and a
// saturating count of accepted transactions whose result is true.
module comparator_pipe
  import cmp_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [OP_W-1:0]    op,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               result,
  output logic               gt,
  output logic               eq,
  output logic               lt,
  output logic               op_err,
  input  logic               cnt_clr,
  output logic [COUNT_W-1:0] true_cnt
);

  localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};
  localparam logic [COUNT_W-1:0] CNT_ONE = COUNT_W'(1'b1);

  rel_t               rel_s;
  logic               accept_s;
  logic               xfer_s;
  logic               result_s;
  logic               op_err_s;
  logic [COUNT_W-1:0] cnt_nxt_s;

  logic               out_valid_r;
  logic               result_r;
  rel_t               rel_r;
  logic               op_err_r;
  logic [COUNT_W-1:0] cnt_r;

  cmp_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
    .gt          (rel_s.gt),
    .eq          (rel_s.eq),
    .lt          (rel_s.lt)
  );

  assign in_ready = ~out_valid_r | out_ready;
  assign accept_s = in_valid & in_ready;
  assign xfer_s   = out_valid_r & out_ready;

  // Op decode for the pair currently on the inputs.
  always_comb begin
    op_err_s = op_is_reserved(op);
    result_s = op_result(op, rel_s);
  end

  // Counter next value: clear dominates, then a saturating increment.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (cnt_clr) begin
      cnt_nxt_s = {COUNT_W{1'b0}};
    end else if (accept_s && result_s && (cnt_r != CNT_MAX)) begin
      cnt_nxt_s = cnt_r + CNT_ONE;
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Output register: reload on acceptance, drop valid after a bare transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      result_r    <= 1'b0;
      rel_r       <= '{gt: 1'b0, eq: 1'b0, lt: 1'b0};
      op_err_r    <= 1'b0;
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      result_r    <= result_s;
      rel_r       <= rel_s;
      op_err_r    <= op_err_s;
    end else if (xfer_s) begin
      out_valid_r <= 1'b0;
    end
  end

  // True-result counter, independent of output back-pressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {COUNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign gt        = rel_r.gt;
  assign eq        = rel_r.eq;
  assign lt        = rel_r.lt;
  assign op_err    = op_err_r;
  assign true_cnt  = cnt_r;

endmodule

// File: tb/tb_comparator_pipe.sv
// Scoreboard bench for comparator_pipe: directed pairs with hand-computed
// flags are queued on acceptance and checked whenever the output is valid.
module tb_comparator_pipe;

  localparam int WIDTH   = 8;
  localparam int COUNT_W = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [WIDTH-1:0]   a = 8'h00;
  logic [WIDTH-1:0]   b = 8'h00;
  logic [2:0]         op = 3'd0;
  logic               signed_mode = 1'b0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic               result;
  logic               gt;
  logic               eq;
  logic               lt;
  logic               op_err;
  logic               cnt_clr = 1'b0;
  logic [COUNT_W-1:0] true_cnt;

  comparator_pipe #(
    .WIDTH   (WIDTH),
    .COUNT_W (COUNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .op          (op),
    .signed_mode (signed_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .gt          (gt),
    .eq          (eq),
    .lt          (lt),
    .op_err      (op_err),
    .cnt_clr     (cnt_clr),
    .true_cnt    (true_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Expected {result, gt, eq, lt, op_err} of the pair on the inputs.
  logic [4:0]         e_exp = 5'b00000;
  logic [4:0]         sb_q[$];
  logic               m_valid = 1'b0;
  logic               m_acc = 1'b0;
  logic [COUNT_W-1:0] m_cnt = 2'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor and model, evaluated mid-cycle while everything is stable.
  initial begin
    logic acc;
    logic xfer;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("in_ready", {31'd0, in_ready}, {31'd0, (!m_valid || out_ready)});
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        if (m_valid) begin
          if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
          end else begin
            chk("flags", {27'd0, result, gt, eq, lt, op_err}, {27'd0, sb_q[0]});
          end
        end
        chk("true_cnt", {30'd0, true_cnt}, {30'd0, m_cnt});
        acc  = in_valid && (!m_valid || out_ready);
        xfer = m_valid && out_ready;
        if (xfer && sb_q.size() > 0) void'(sb_q.pop_front());
        if (acc) sb_q.push_back(e_exp);
        if (acc) m_valid = 1'b1;
        else if (xfer) m_valid = 1'b0;
        if (cnt_clr) m_cnt = 2'd0;
        else if (acc && e_exp[4] && m_cnt != 2'd3) m_cnt = m_cnt + 2'd1;
        m_acc = acc;
      end else begin
        m_acc = 1'b0;
      end
    end
  end

  // Asynchronous reset empties the model immediately.
  initial begin
    forever begin
      @(negedge rst_n);
      m_valid = 1'b0;
      m_cnt   = 2'd0;
      m_acc   = 1'b0;
      sb_q.delete();
    end
  end

  // Present one pair and hold it until accepted; called #1 after a rising edge.
  task automatic issue(input logic [7:0] ta, input logic [7:0] tb_v, input logic [2:0] top,
                       input logic tsm, input logic [4:0] texp);
    int n;
    a = ta; b = tb_v; op = top; signed_mode = tsm; e_exp = texp; in_valid = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!m_acc && n < 50);
    if (!m_acc) chk("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  logic [1:0] sat_tbl [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outs", {25'd0, out_valid, result, gt, eq, lt, op_err, true_cnt},
        {25'd0, 7'b0000000});
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    issue(8'hC8, 8'h64, 3'd0, 1'b0, 5'b11000);
    chk("gt_unsigned_cnt", {30'd0, true_cnt}, 32'd1);
    issue(8'hC8, 8'h64, 3'd0, 1'b1, 5'b00010);
    issue(8'h80, 8'h80, 3'd3, 1'b1, 5'b10100);
    issue(8'h7F, 8'h80, 3'd1, 1'b0, 5'b00010);
    issue(8'h7F, 8'h80, 3'd1, 1'b1, 5'b11000);
    issue(8'h00, 8'hFF, 3'd2, 1'b0, 5'b10010);
    issue(8'h33, 8'h33, 3'd5, 1'b0, 5'b00100);

    // Stall for three cycles; the second pair must wait, then ride the transfer.
    issue(8'h05, 8'h05, 3'd4, 1'b0, 5'b10100);
    out_ready = 1'b0;
    fork
      issue(8'h03, 8'h07, 3'd5, 1'b0, 5'b10010);
      begin
        repeat (3) @(posedge clk);
        #1;
        chk("stall_hold", {30'd0, eq, result}, {30'd0, 2'b11});
        out_ready = 1'b1;
      end
    join

    issue(8'h01, 8'h00, 3'd6, 1'b0, 5'b01001);
    issue(8'hFF, 8'h01, 3'd7, 1'b1, 5'b00011);

    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    chk("cnt_clr_idle", {30'd0, true_cnt}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      issue(8'h02, 8'h01, 3'd0, 1'b0, 5'b11000);
      chk("sat_cnt", {30'd0, true_cnt}, {30'd0, sat_tbl[i]});
    end
    cnt_clr = 1'b1;
    issue(8'h02, 8'h01, 3'd0, 1'b0, 5'b11000);
    cnt_clr = 1'b0;
    chk("clr_wins", {30'd0, true_cnt}, 32'd0);

    // Back-to-back stream, then reset asserted between clock edges.
    issue(8'h10, 8'h20, 3'd2, 1'b0, 5'b10010);
    issue(8'h20, 8'h10, 3'd1, 1'b0, 5'b11000);
    issue(8'h90, 8'h10, 3'd2, 1'b1, 5'b10010);
    a = 8'h44; b = 8'h44; op = 3'd4; signed_mode = 1'b0; e_exp = 5'b10100;
    in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_cnt", {30'd0, true_cnt}, 32'd0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold", {25'd0, out_valid, result, gt, eq, lt, op_err, true_cnt},
        {25'd0, 7'b0000000});
    rst_n = 1'b1;
    issue(8'h80, 8'h7F, 3'd2, 1'b1, 5'b10010);
    repeat (3) @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
